// File: rtl/cbus_arbiter_if.sv
// -----------------------------------------------------------------------------
// cbus_pkg / cbus_arbiter_if
//
// Purpose:
//   CBus request/response types shared by the cache layer, the arbiter and the
//   AXI/CBus bridge, plus the interface that bundles the arbiter's cache-side
//   and memory-side buses.
//
// Interface signals (cbus_arbiter_if):
//   ireqs  [NUM_REQ]  per-requester CBus requests (cache -> arbiter)
//   iresps [NUM_REQ]  per-requester responses     (arbiter -> cache)
//   oreq              request to memory            (arbiter -> bridge)
//   oresp             response from memory         (bridge -> arbiter)
//
// Modports:
//   slave  - arbiter view: consumes ireqs/oresp, produces iresps/oreq
//   master - environment view (caches + bridge): the mirror image
// -----------------------------------------------------------------------------
package cbus_pkg;

  typedef logic [2:0] msize_t;
  typedef logic [1:0] axi_burst_t;

  localparam axi_burst_t AXI_BURST_INCR = 2'b01;

  // Burst length encoded as beats-1, as on AXI.
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } mlen_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
    axi_burst_t  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

interface cbus_arbiter_if #(
  parameter int NUM_REQ = 2
);

  cbus_pkg::cbus_req_t  ireqs  [NUM_REQ];
  cbus_pkg::cbus_resp_t iresps [NUM_REQ];
  cbus_pkg::cbus_req_t  oreq;
  cbus_pkg::cbus_resp_t oresp;

  modport slave (
    input  ireqs,
    input  oresp,
    output iresps,
    output oreq
  );

  modport master (
    output ireqs,
    output oresp,
    input  iresps,
    input  oreq
  );

endinterface

// File: rtl/cbus_arbiter.sv
// -----------------------------------------------------------------------------
// cbus_arbiter
//
// Purpose:
//   Shares the single memory-side CBus between NUM_REQ cache requesters
//   (e.g. ICache on port 0, DCache on port 1). One requester is granted at a
//   time and keeps the grant for its whole burst (refill or writeback) until
//   memory returns ready&last. Selection is round-robin starting at a
//   priority pointer that moves past the requester just served.
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous, active-high reset
//   bus        if   cbus_arbiter_if.slave: ireqs/iresps (cache side),
//                   oreq/oresp (memory side)
//   busy       out  high while a transaction is granted
//   grant_idx  out  granted requester index; meaningful only while busy
// -----------------------------------------------------------------------------
module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int IDX_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                clk,
  input  logic                reset,
  cbus_arbiter_if.slave       bus,
  output logic                busy,
  output logic [IDX_BITS-1:0] grant_idx
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e              state_q;
  logic [IDX_BITS-1:0] grant_q;
  logic [IDX_BITS-1:0] ptr_q;
  logic [IDX_BITS-1:0] ptr_d;
  logic [IDX_BITS-1:0] arb_idx;
  logic                arb_found;

  // (base + off) mod NUM_REQ; off never exceeds NUM_REQ-1.
  function automatic logic [IDX_BITS-1:0] wrap_idx(
    input logic [IDX_BITS-1:0] base,
    input int                  off
  );
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_BITS'(s);
  endfunction

  // Round-robin search: first valid requester at or after ptr, wrapping.
  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!arb_found && bus.ireqs[wrap_idx(ptr_q, k)].valid) begin
        arb_found = 1'b1;
        arb_idx   = wrap_idx(ptr_q, k);
      end
    end
  end

  // Priority moves to the requester after the one just served.
  assign ptr_d = (grant_q == IDX_BITS'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  // Grant FSM. Leaving BUSY always lands in IDLE for one cycle, which is the
  // arbitration bubble that guarantees oreq.valid drops between bursts.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_found) begin
            grant_q <= arb_idx;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // Other ports' valid changes are irrelevant here; only the
          // memory's final beat ends the grant, even if the owner dropped
          // valid early.
          if (bus.oresp.ready && bus.oresp.last) begin
            state_q <= IDLE;
            ptr_q   <= ptr_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath mux. oreq depends only on state and ireqs, never on oresp, so
  // there is no combinational loop through the bridge. Because reset forces
  // state_q to IDLE asynchronously, oreq.valid drops as soon as reset rises.
  always_comb begin
    bus.oreq = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.iresps[i].ready = 1'b0;
      bus.iresps[i].last  = 1'b0;
      // Read data is broadcast; ports without ready simply ignore it.
      bus.iresps[i].data  = bus.oresp.data;
    end
    if (state_q == BUSY) begin
      bus.oreq = bus.ireqs[grant_q];
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_q == IDX_BITS'(i)) begin
          bus.iresps[i].ready = bus.oresp.ready;
          bus.iresps[i].last  = bus.oresp.last;
        end
      end
    end
  end

  assign busy      = (state_q == BUSY);
  assign grant_idx = grant_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cbus_arbiter
//
// Self-checking bench for cbus_arbiter. Two instances are used: a 2-port one
// for most sequences and a 3-port one for pointer wrap-around. Inputs are
// driven on the falling edge and outputs sampled 1 ns later, well away from
// the rising (active) edge.
// -----------------------------------------------------------------------------
module tb_cbus_arbiter;
  import cbus_pkg::*;

  logic clk;
  logic reset;

  logic       busy2;
  logic [0:0] gidx2;
  logic       busy3;
  logic [1:0] gidx3;

  cbus_arbiter_if #(.NUM_REQ(2)) bus2 ();
  cbus_arbiter_if #(.NUM_REQ(3)) bus3 ();

  cbus_arbiter #(.NUM_REQ(2)) dut2 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus2.slave),
    .busy      (busy2),
    .grant_idx (gidx2)
  );

  cbus_arbiter #(.NUM_REQ(3)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus3.slave),
    .busy      (busy3),
    .grant_idx (gidx3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected per-beat data, pushed when the beat is driven, popped when the
  // DUT shows it.
  logic [63:0] sb_q[$];

  typedef struct {
    logic [1:0] vmask;   // ireqs[1:0].valid
    logic       rdy;     // oresp.ready
    logic       lst;     // oresp.last
    logic       ovalid;  // expected oreq.valid
    logic       busy;    // expected busy
    logic       gidx;    // expected grant_idx (checked when busy)
    logic [1:0] r;       // expected iresps[1:0].ready
    logic [1:0] l;       // expected iresps[1:0].last
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [63:0] act);
    logic [63:0] exp;
    if (sb_q.size() == 0) begin
      check({name, " (scoreboard empty)"}, 64'd1, 64'd0);
    end else begin
      exp = sb_q.pop_front();
      check(name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic cbus_req_t mk_req(input logic v, input logic wr,
                                       input logic [31:0] addr, input logic [63:0] data);
    cbus_req_t r;
    r          = '0;
    r.valid    = v;
    r.is_write = wr;
    r.size     = 3'd3;
    r.addr     = addr;
    r.strobe   = wr ? 8'hFF : 8'h00;
    r.data     = data;
    r.len      = MLEN16;
    r.burst    = AXI_BURST_INCR;
    return r;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) bus2.ireqs[i] = '0;
    for (int i = 0; i < 3; i++) bus3.ireqs[i] = '0;
    bus2.oresp = '0;
    bus3.oresp = '0;
  endtask

  // Leaves the bench on a falling edge with reset just released.
  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    sb_q.delete();
    repeat (2) tick();
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int cnt_r, cnt_l, cnt_r0, idle, waited, exp_g, model_ptr;

    // Per-cycle vectors from reset on the 2-port arbiter.
    //               vmask  rdy   lst   ov    busy  g     r      l
    vecs[0]  = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00}; // stray resp in IDLE
    vecs[1]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[2]  = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00}; // bubble, ptr=0 -> 0
    vecs[3]  = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00};
    vecs[4]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b01}; // last -> ptr=1
    vecs[5]  = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00}; // one IDLE bubble
    vecs[6]  = '{2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b10}; // port 1 served
    vecs[7]  = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[8]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00}; // owner drops valid
    vecs[9]  = '{2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00}; // still granted to 1
    vecs[10] = '{2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 2'b10}; // exits on last only
    vecs[11] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[12] = '{2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b01};
    vecs[13] = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00}; // stray again
    vecs[14] = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00}; // ptr=1 -> 1
    vecs[15] = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 2'b10};
    vecs[16] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};

    reset = 1'b1;
    clear_inputs();
    #2;
    check("reset busy", 64'(busy2), 64'd0);
    check("reset grant_idx", 64'(gidx2), 64'd0);
    check("reset oreq.valid", 64'(bus2.oreq.valid), 64'd0);

    // ---------------- table-driven vectors ----------------
    do_reset();
    bus2.ireqs[0] = mk_req(1'b0, 1'b0, 32'h0000_0100, 64'd0);
    bus2.ireqs[1] = mk_req(1'b0, 1'b0, 32'h0000_0200, 64'd0);
    for (int i = 0; i < 17; i++) begin
      bus2.ireqs[0].valid = vecs[i].vmask[0];
      bus2.ireqs[1].valid = vecs[i].vmask[1];
      bus2.oresp.ready    = vecs[i].rdy;
      bus2.oresp.last     = vecs[i].lst;
      #1;
      check($sformatf("vec%0d oreq.valid", i), 64'(bus2.oreq.valid), 64'(vecs[i].ovalid));
      check($sformatf("vec%0d busy", i), 64'(busy2), 64'(vecs[i].busy));
      if (vecs[i].busy) begin
        check($sformatf("vec%0d grant_idx", i), 64'(gidx2), 64'(vecs[i].gidx));
        check($sformatf("vec%0d oreq.addr", i), 64'(bus2.oreq.addr),
              vecs[i].gidx ? 64'h200 : 64'h100);
      end
      check($sformatf("vec%0d ready", i),
            64'({bus2.iresps[1].ready, bus2.iresps[0].ready}), 64'(vecs[i].r));
      check($sformatf("vec%0d last", i),
            64'({bus2.iresps[1].last, bus2.iresps[0].last}), 64'(vecs[i].l));
      tick();
    end

    // ---------------- single requester read refill ----------------
    do_reset();
    bus2.ireqs[1] = mk_req(1'b1, 1'b0, 32'h8000_0040, 64'd0);
    #1;
    check("A bubble oreq.valid", 64'(bus2.oreq.valid), 64'd0);
    tick();
    #1;
    check("A oreq.valid rises", 64'(bus2.oreq.valid), 64'd1);
    check("A oreq.addr", 64'(bus2.oreq.addr), 64'h8000_0040);
    check("A grant_idx", 64'(gidx2), 64'd1);
    tick();
    cnt_r = 0; cnt_l = 0; cnt_r0 = 0;
    for (int b = 0; b < 16; b++) begin
      bus2.oresp.ready = 1'b1;
      bus2.oresp.last  = (b == 15);
      bus2.oresp.data  = 64'hA000 + 64'(b);
      sb_q.push_back(64'hA000 + 64'(b));
      #1;
      if (bus2.iresps[1].ready) begin
        cnt_r++;
        sb_check($sformatf("A beat%0d data", b), bus2.iresps[1].data);
      end
      if (bus2.iresps[1].last) cnt_l++;
      if (bus2.iresps[0].ready) cnt_r0++;
      tick();
    end
    bus2.oresp = '0;
    bus2.ireqs[1].valid = 1'b0;
    #1;
    check("A ready beats", 64'(cnt_r), 64'd16);
    check("A last beats", 64'(cnt_l), 64'd1);
    check("A port0 ready", 64'(cnt_r0), 64'd0);
    check("A idle after last", 64'(busy2), 64'd0);
    check("A scoreboard drained", 64'(sb_q.size()), 64'd0);
    tick();

    // ---------------- round-robin, both valid from reset ----------------
    do_reset();
    bus2.ireqs[0] = mk_req(1'b1, 1'b0, 32'h0000_0100, 64'd0);
    bus2.ireqs[1] = mk_req(1'b1, 1'b0, 32'h0000_0200, 64'd0);
    model_ptr = 0;
    for (int b = 0; b < 4; b++) begin
      idle = 0; waited = 0;
      #1;
      while (!busy2 && waited < 4) begin
        if (!bus2.oreq.valid) idle++;
        tick();
        #1;
        waited++;
      end
      exp_g = model_ptr;
      model_ptr = (exp_g + 1) % 2;
      check($sformatf("B burst%0d idle cycles", b), 64'(idle), 64'd1);
      check($sformatf("B burst%0d grant", b), 64'(gidx2), 64'(exp_g));
      tick();
      for (int k = 0; k < 4; k++) begin
        bus2.oresp.ready = 1'b1;
        bus2.oresp.last  = (k == 3);
        #1;
        if (gidx2 !== 1'(exp_g) || !bus2.oreq.valid)
          check($sformatf("B burst%0d beat%0d grant held", b, k),
                64'({gidx2, bus2.oreq.valid}), 64'({1'(exp_g), 1'b1}));
        tick();
      end
      bus2.oresp = '0;
    end

    // ---------------- writeback pass-through ----------------
    do_reset();
    bus2.ireqs[1] = mk_req(1'b1, 1'b1, 32'h8000_1000, 64'h10);
    #1;
    check("C bubble busy", 64'(busy2), 64'd0);
    tick();
    for (int k = 0; k < 16; k++) begin
      bus2.ireqs[1].data = 64'h10 + 64'(k);
      sb_q.push_back(64'h10 + 64'(k));
      if (k == 5) bus2.ireqs[0] = mk_req(1'b1, 1'b0, 32'h0000_0100, 64'd0);
      bus2.oresp.ready = 1'b1;
      bus2.oresp.last  = (k == 15);
      #1;
      sb_check($sformatf("C beat%0d oreq.data", k), bus2.oreq.data);
      check($sformatf("C beat%0d grant", k), 64'(gidx2), 64'd1);
      if (k == 0) begin
        check("C is_write", 64'(bus2.oreq.is_write), 64'd1);
        check("C strobe", 64'(bus2.oreq.strobe), 64'hFF);
      end
      tick();
    end
    bus2.oresp = '0;
    bus2.ireqs[1].valid = 1'b0;
    #1;
    check("C idle after last busy", 64'(busy2), 64'd0);
    check("C idle after last oreq.valid", 64'(bus2.oreq.valid), 64'd0);
    tick();
    #1;
    check("C port0 granted busy", 64'(busy2), 64'd1);
    check("C port0 granted idx", 64'(gidx2), 64'd0);
    check("C port0 addr", 64'(bus2.oreq.addr), 64'h100);
    tick();
    bus2.oresp.ready = 1'b1;
    bus2.oresp.last  = 1'b1;
    bus2.ireqs[0].valid = 1'b0;
    tick();
    clear_inputs();

    // ---------------- wrap-around, 3 ports ----------------
    do_reset();
    bus3.ireqs[1] = mk_req(1'b1, 1'b0, 32'h0000_0200, 64'd0);
    #1;
    check("D bubble", 64'(busy3), 64'd0);
    tick();
    bus3.oresp.ready = 1'b1;
    bus3.oresp.last  = 1'b1;
    #1;
    check("D first grant", 64'(gidx3), 64'd1);
    tick();
    bus3.oresp = '0;
    bus3.ireqs[1].valid = 1'b0;
    bus3.ireqs[0] = mk_req(1'b1, 1'b0, 32'h0000_0100, 64'd0);
    bus3.ireqs[2] = mk_req(1'b1, 1'b0, 32'h0000_0300, 64'd0);
    #1;
    check("D idle between", 64'(busy3), 64'd0);
    tick();
    bus3.oresp.ready = 1'b1;
    bus3.oresp.last  = 1'b1;
    #1;
    check("D wrap grant port2", 64'(gidx3), 64'd2);
    check("D wrap port2 ready", 64'(bus3.iresps[2].ready), 64'd1);
    check("D wrap port0 ready", 64'(bus3.iresps[0].ready), 64'd0);
    tick();
    bus3.oresp = '0;
    bus3.ireqs[2].valid = 1'b0;
    #1;
    check("D idle before port0", 64'(bus3.oreq.valid), 64'd0);
    tick();
    bus3.oresp.ready = 1'b1;
    bus3.oresp.last  = 1'b1;
    #1;
    check("D then port0", 64'(gidx3), 64'd0);
    check("D port0 busy", 64'(busy3), 64'd1);
    tick();
    clear_inputs();

    // ---------------- reset mid-burst ----------------
    do_reset();
    bus2.ireqs[0] = mk_req(1'b1, 1'b0, 32'h0000_0100, 64'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      bus2.oresp.ready = 1'b1;
      bus2.oresp.last  = 1'b0;
      #1;
      check($sformatf("E beat%0d grant", k), 64'({busy2, gidx2}), 64'b10);
      if (k == 4) begin
        reset = 1'b1;
        bus2.ireqs[0].valid = 1'b0;
        bus2.ireqs[1] = mk_req(1'b1, 1'b0, 32'h0000_0200, 64'd0);
        #1;
        check("E reset oreq.valid", 64'(bus2.oreq.valid), 64'd0);
        check("E reset busy", 64'(busy2), 64'd0);
        check("E reset port0 ready", 64'(bus2.iresps[0].ready), 64'd0);
      end
      tick();
    end
    tick();
    reset = 1'b0;
    bus2.oresp = '0;
    #1;
    check("E after release idle", 64'(busy2), 64'd0);
    tick();
    #1;
    check("E pending port1 busy", 64'(busy2), 64'd1);
    check("E pending port1 idx", 64'(gidx2), 64'd1);
    tick();
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- Shares the single memory-side cache bus (CBus) between NUM_REQ cache requesters, e.g. ICache on port 0 and DCache on port 1.
- Grants one requester at a time and holds the grant for a whole burst transaction, including read refill and dirty-line writeback (len = MLEN16).
- Arbitration is round-robin, so a DCache writeback followed by a refill cannot starve ICache fetches.
- Sits between the cache layer and the AXI/CBus bridge.

Parameters:
- NUM_REQ, 2, number of requester ports (2..8); port index 0 has the highest priority after reset.
- IDX_BITS, $clog2(NUM_REQ) (minimum 1), width of the grant index.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ireqs  in  NUM_REQ x cbus_req_t  per-requester CBus requests: valid, is_write, size, addr, strobe, data, len, burst.
- iresps  out  NUM_REQ x cbus_resp_t  per-requester responses: ready, last, data.
- oreq  out  cbus_req_t  request to memory.
- oresp  in  cbus_resp_t  response from memory.
- busy  out  1  high while a transaction is granted.
- grant_idx  out  IDX_BITS  index of the granted requester; valid only while busy is high.

Behaviour:
- Clocking: one clock (clk); reset is asynchronous and active-high (reset). All state is in flops that reset asynchronously.
- Reset values: state=IDLE, grant_idx=0, busy=0, priority pointer ptr=0.
- Output values while reset is high: oreq all zero (valid=0), every iresps ready=0 and last=0.
- State IDLE:
  - oreq='0; all iresps.ready=0 and last=0.
  - Combinationally search from ptr upward, wrapping modulo NUM_REQ, for the first index i with ireqs[i].valid=1.
  - If one is found: at the next clock edge grant_idx<=i and state<=BUSY.
  - Arbitration costs exactly 1 bubble cycle; oreq.valid first rises in the cycle after the request is seen.
- State BUSY:
  - oreq = ireqs[grant_idx], forwarded unmodified and combinationally, every cycle, so the requester's beat-by-beat write data passes straight through.
  - iresps[grant_idx].ready/last = oresp.ready/last.
  - All other iresps: ready=0, last=0.
  - iresps[*].data = oresp.data, broadcast to every port; non-granted ports must ignore it.
- BUSY exit: on a cycle with oresp.ready=1 and oresp.last=1:
  - state<=IDLE;
  - ptr<=grant_idx+1, wrapping to 0 when grant_idx=NUM_REQ-1.
- Back-to-back requests: after a burst ends there is one IDLE cycle before the next grant, even if requests are pending. This guarantees oreq.valid drops between transactions, as the bridge requires.
- Grant stability: the grant never changes mid-burst. New or withdrawn valid on other ports is ignored while BUSY.
- Granted requester drops valid before last (protocol violation):
  - the arbiter stays BUSY and forwards valid=0;
  - no timeout;
  - it leaves BUSY only on oresp.last.
- Simultaneous events: if the last beat and a new request on any port occur in the same cycle, the new request is arbitrated in the following IDLE cycle using the updated ptr.
- oresp.ready/last arriving while IDLE are ignored and are not forwarded.
- busy = (state==BUSY).
- Reset mid-burst: the arbiter returns to IDLE immediately and oreq.valid drops asynchronously. The bridge and the caches are reset by the same signal.
- No combinational path from oresp to oreq.

Test Plan:
- Single requester: ireqs[1] read, addr=0x8000_0040, len=MLEN16; memory asserts ready on 16 beats, last on the 16th.
  - Expect: oreq.valid rises 1 cycle after ireqs[1].valid; addr 0x8000_0040 forwarded; iresps[1] sees 16 ready and 1 last; iresps[0].ready stays 0; state IDLE after last.
- Round-robin: both ports valid continuously from reset.
  - Expect: grants in the order 0,1,0,1 across 4 bursts, with exactly one IDLE cycle (oreq.valid=0) between bursts.
- Writeback pass-through: port 1 writes with is_write=1, strobe=8'hFF, and data changing each beat as 0x10..0x1F.
  - Expect: oreq.data matches each beat in the same cycle; port 0 valid raised mid-burst is not granted until after last plus one IDLE cycle.
- Wrap-around with NUM_REQ=3: ptr=2 after a grant to port 1; ports 0 and 2 both valid.
  - Expect: port 2 granted first, then port 0.
- Reset mid-burst: assert reset at beat 5 of a grant to port 0.
  - Expect: in the same cycle oreq.valid=0 and busy=0; after release, ptr=0 and a pending port 1 request is granted 1 cycle later.
- Stray response in IDLE: oresp.ready=1 and last=1 with no grant.
  - Expect: all iresps.ready/last stay 0 and ptr is unchanged.
